iq_phase_direction: RTL

Parametrised successor to the ZigBee CORDIC direction path. Captures one signed I/Q sample per enable strobe and computes its phase with an iterative vectoring CORDIC, one iteration per cycle. Compares that phase with the previous sample's phase (modulo 2π) and reports rotation direction with a one-cycle output strobe. Sits between the I/Q sampler and the chip/bit decision logic of the O-QPSK receiver.

---
 rtl/cordic_pkg.sv | 58 +++++
 rtl/cordic_vectoring_iter.sv | 83 ++++++++
 rtl/iq_phase_direction.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: FSM state encoding and arctangent table for the iterative
// vectoring CORDIC used by iq_phase_direction.
package cordic_pkg;

    localparam int MAX_ITER = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LOAD,
        ITER,
        UPDATE,
        OUT
    } state_t;

    typedef logic [MAX_ITER-1:0][31:0] atan_table_t;

    // atan(2^-i) scaled so that 2^32 is one full turn
    function automatic logic [31:0] atan_full(input int i);
        logic [31:0] value;
        case (i)
            0:       value = 32'd536870912;
            1:       value = 32'd316933406;
            2:       value = 32'd167458907;
            3:       value = 32'd85004756;
            4:       value = 32'd42667331;
            5:       value = 32'd21354465;
            6:       value = 32'd10679838;
            7:       value = 32'd5340245;
            8:       value = 32'd2670163;
            9:       value = 32'd1335087;
            10:      value = 32'd667544;
            11:      value = 32'd333772;
            12:      value = 32'd166886;
            13:      value = 32'd83443;
            14:      value = 32'd41722;
            15:      value = 32'd20861;
            default: value = 32'd0;
        endcase
        return value;
    endfunction

    function automatic atan_table_t atan_table(input int ang_w);
        atan_table_t table_out;
        logic [32:0] scaled;
        table_out = '0;
        for (int i = 0; i < MAX_ITER; i++) begin
            if (ang_w >= 32) begin
                table_out[i] = atan_full(i);
            end else begin
                scaled = ({1'b0, atan_full(i)} + (33'd1 << (31 - ang_w))) >> (32 - ang_w);
                table_out[i] = scaled[31:0];
            end
        end
        return table_out;
    endfunction

endpackage

// File: rtl/cordic_vectoring_iter.sv
// cordic_vectoring_iter: quadrant pre-rotation on start, then N_ITER vectoring
// iterations (one per clock) that drive y to zero while accumulating the angle.
module cordic_vectoring_iter #(
    parameter int IQ_W   = 4,
    parameter int ANG_W  = 16,
    parameter int N_ITER = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic signed [IQ_W-1:0] sample_i,
    input  logic signed [IQ_W-1:0] sample_q,
    output logic                   done,
    output logic [ANG_W-1:0]       angle,
    output logic                   zero
);
    import cordic_pkg::*;

    localparam int XY_W  = IQ_W + 3;
    localparam int CNT_W = $clog2(MAX_ITER);
    localparam atan_table_t ATAN_TABLE = atan_table(ANG_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);
    localparam logic [ANG_W-1:0] HALF_TURN = {1'b1, {(ANG_W-1){1'b0}}};

    logic signed [XY_W-1:0] x;
    logic signed [XY_W-1:0] y;
    logic signed [XY_W-1:0] x_shift;
    logic signed [XY_W-1:0] y_shift;
    logic signed [XY_W-1:0] ext_i;
    logic signed [XY_W-1:0] ext_q;
    logic [CNT_W-1:0]       iter;
    logic                   busy;
    logic [ANG_W-1:0]       atan_step;

    assign ext_i     = {{3{sample_i[IQ_W-1]}}, sample_i};
    assign ext_q     = {{3{sample_q[IQ_W-1]}}, sample_q};
    assign x_shift   = x >>> iter;
    assign y_shift   = y >>> iter;
    assign atan_step = ATAN_TABLE[iter][ANG_W-1:0];
    assign done      = busy && (iter == LAST_ITER);

    // Left half-plane vectors are flipped by pi first so the iterations only
    // ever have to cover +-90 degrees; y >= 0 rotates clockwise.
    always_ff @(posedge clock) begin
        if (!reset) begin
            x     <= '0;
            y     <= '0;
            angle <= '0;
            iter  <= '0;
            busy  <= 1'b0;
            zero  <= 1'b0;
        end else if (start) begin
            if (ext_i[XY_W-1]) begin
                x     <= -ext_i;
                y     <= -ext_q;
                angle <= HALF_TURN;
            end else begin
                x     <= ext_i;
                y     <= ext_q;
                angle <= '0;
            end
            iter <= '0;
            busy <= 1'b1;
            zero <= (sample_i == '0) && (sample_q == '0);
        end else if (busy) begin
            if (!y[XY_W-1]) begin
                x     <= x + y_shift;
                y     <= y - x_shift;
                angle <= angle + atan_step;
            end else begin
                x     <= x - y_shift;
                y     <= y + x_shift;
                angle <= angle - atan_step;
            end
            if (done) begin
                busy <= 1'b0;
            end else begin
                iter <= iter + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iq_phase_direction.sv
// iq_phase_direction: CORDIC phase per I/Q sample and rotation direction versus
// the previous sample. Define PHASE_OUT_EN to expose o_angle and o_delta.
module iq_phase_direction #(
    parameter int IQ_W      = 4,
    parameter int ANG_W     = 16,
    parameter int N_ITER    = 12,
    parameter int DEAD_ZONE = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_enable_in,
    input  logic signed [IQ_W-1:0]  i_I,
    input  logic signed [IQ_W-1:0]  i_Q,
    output logic                    o_enable_out,
    output logic                    o_dir,
    output logic                    o_overrun
`ifdef PHASE_OUT_EN
    ,
    output logic [ANG_W-1:0]        o_angle,
    output logic signed [ANG_W-1:0] o_delta
`endif
);
    import cordic_pkg::*;

    localparam logic [ANG_W:0]   DEAD_LIMIT = (ANG_W + 1)'(DEAD_ZONE);
    localparam logic [ANG_W-1:0] HALF_TURN  = {1'b1, {(ANG_W-1){1'b0}}};

    state_t                 state;
    logic signed [IQ_W-1:0] sample_i;
    logic signed [IQ_W-1:0] sample_q;
    logic [ANG_W-1:0]       angle;
    logic [ANG_W-1:0]       angle_prev;
    logic [ANG_W-1:0]       delta;
    logic [ANG_W-1:0]       delta_mag;
    logic                   primed;
    logic                   zero;
    logic                   done;
    logic                   start;
    logic                   half_turn;
    logic                   in_dead_zone;
    logic                   delta_pos;

    assign start = (state == LOAD);

    cordic_vectoring_iter #(
        .IQ_W   (IQ_W),
        .ANG_W  (ANG_W),
        .N_ITER (N_ITER)
    ) u_cordic (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .sample_i (sample_i),
        .sample_q (sample_q),
        .done     (done),
        .angle    (angle),
        .zero     (zero)
    );

    // Modular subtraction makes a 0/2pi crossing come out as a small delta
    assign delta        = angle - angle_prev;
    assign delta_mag    = delta[ANG_W-1] ? -delta : delta;
    assign half_turn    = (delta == HALF_TURN);
    assign in_dead_zone = ({1'b0, delta_mag} <= DEAD_LIMIT);
    assign delta_pos    = !delta[ANG_W-1] && (delta != '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            sample_i     <= '0;
            sample_q     <= '0;
            angle_prev   <= '0;
            primed       <= 1'b0;
            o_enable_out <= 1'b0;
            o_dir        <= 1'b0;
            o_overrun    <= 1'b0;
`ifdef PHASE_OUT_EN
            o_angle      <= '0;
            o_delta      <= '0;
`endif
        end else begin
            o_enable_out <= 1'b0;
            o_overrun    <= 1'b0;
            case (state)
                IDLE: state <= WAIT;
                WAIT: begin
                    if (i_enable_in) begin
                        sample_i <= i_I;
                        sample_q <= i_Q;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    o_overrun <= i_enable_in;
                    state     <= ITER;
                end
                ITER: begin
                    o_overrun <= i_enable_in;
                    if (done) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    o_overrun    <= i_enable_in;
                    o_enable_out <= 1'b1;
                    // A zero vector has no phase, so it must not disturb the reference
                    if (!zero) begin
                        if (primed && !in_dead_zone && !half_turn) begin
                            o_dir <= delta_pos;
                        end
                        angle_prev <= angle;
                        primed     <= 1'b1;
                    end
`ifdef PHASE_OUT_EN
                    o_angle <= angle;
                    o_delta <= (primed && !zero) ? delta : '0;
`endif
                    state <= OUT;
                end
                OUT: begin
                    if (i_enable_in) begin
                        sample_i <= i_I;
                        sample_q <= i_Q;
                        state    <= LOAD;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
